// File: rtl/adsr_voice_engine.sv
`timescale 1ns/1ps
// adsr_voice_engine
//   Time-multiplexed ADSR envelope engine. Each sample tick starts a sweep
//   that visits every voice once, one voice per clock. Per-voice envelope
//   state, volume, latched MIDI channel, drum hold counter and pending note
//   flags live in internal register arrays.
//
//   Ports
//     i_clk, i_rst_n          clock, asynchronous active-low reset
//     i_sample_tick           starts a sweep when idle
//     i_attack_rate           added per sweep in ATTACK
//     i_decay_rate            subtracted per sweep in DECAY
//     i_release_rate          subtracted per sweep in RELEASE
//     i_sustain_value         sustain level (upper bits of the volume)
//     i_evt_*                 note event: voice, press/release, channel
//     o_env_*                 per-voice result stream (one voice per cycle)
//     o_sweep_done            pulses with the last voice's result
//     o_busy                  sweep in progress
//     o_tick_overrun          tick arrived while a sweep was running
//
//   Control FSM
//     state      | meaning
//     CTL_IDLE   | waiting for a sample tick
//     CTL_SWEEP  | processing voice idx_q this cycle
//
//   Envelope states (per voice)
//     state       | meaning
//     ENV_BLANK   | silent, volume 0
//     ENV_ATTACK  | ramping up toward VOL_MAX (drum: one sweep at VOL_MAX)
//     ENV_DECAY   | ramping down toward the sustain level
//     ENV_SUSTAIN | holding at sustain (drum: VOL_MAX while hold runs)
//     ENV_RELEASE | ramping down toward 0

module adsr_voice_engine #(
    parameter int NUM_VOICES   = 16,
    parameter int VOL_W        = 18,
    parameter int RATE_W       = 7,
    parameter int DRUM_CHANNEL = 9,
    parameter int DRUM_HOLD    = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_sample_tick,
    input  logic [RATE_W-1:0]             i_attack_rate,
    input  logic [RATE_W-1:0]             i_decay_rate,
    input  logic [RATE_W-1:0]             i_release_rate,
    input  logic [RATE_W-1:0]             i_sustain_value,
    input  logic                          i_evt_valid,
    input  logic [$clog2(NUM_VOICES)-1:0] i_evt_voice,
    input  logic                          i_evt_on,
    input  logic [3:0]                    i_evt_channel,
    output logic                          o_env_valid,
    output logic [$clog2(NUM_VOICES)-1:0] o_env_voice,
    output logic [2:0]                    o_env_state,
    output logic [VOL_W-1:0]              o_env_volume,
    output logic                          o_sweep_done,
    output logic                          o_busy,
    output logic                          o_tick_overrun
);

    localparam int VI_W   = $clog2(NUM_VOICES);
    localparam int HOLD_W = $clog2(DRUM_HOLD + 1);
    localparam logic [VOL_W-1:0]  VOL_MAX   = {1'b0, {(VOL_W-1){1'b1}}};
    localparam logic [3:0]        DRUM_CH   = 4'(DRUM_CHANNEL);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(DRUM_HOLD);
    localparam logic [VI_W-1:0]   LAST_IDX  = VI_W'(NUM_VOICES - 1);

    typedef enum logic [2:0] {
        ENV_BLANK   = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_e;

    typedef enum logic {CTL_IDLE, CTL_SWEEP} ctl_state_e;

    ctl_state_e          ctl_q, ctl_d;
    logic [VI_W-1:0]     idx_q, idx_d;
    env_state_e          env_q  [NUM_VOICES];
    env_state_e          env_d  [NUM_VOICES];
    logic [VOL_W-1:0]    vol_q  [NUM_VOICES];
    logic [VOL_W-1:0]    vol_d  [NUM_VOICES];
    logic [3:0]          chan_q [NUM_VOICES];
    logic [3:0]          chan_d [NUM_VOICES];
    logic [HOLD_W-1:0]   hold_q [NUM_VOICES];
    logic [HOLD_W-1:0]   hold_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] press_q, press_d;
    logic [NUM_VOICES-1:0] rel_q, rel_d;

    logic                valid_q, valid_d;
    logic [VI_W-1:0]     voice_q, voice_d;
    logic [2:0]          st_out_q, st_out_d;
    logic [VOL_W-1:0]    vol_out_q, vol_out_d;
    logic                done_q, done_d;
    logic                ovr_q, ovr_d;

    // Per-voice datapath for the voice at idx_q
    env_state_e          cur_st, nxt_st;
    logic [VOL_W-1:0]    cur_vol, nxt_vol;
    logic [HOLD_W-1:0]   cur_hold, nxt_hold;
    logic                cur_press, cur_rel, is_drum;
    logic                clr_press, clr_rel;
    logic [VOL_W:0]      atk_sum;
    logic [VOL_W-1:0]    sus_full, dec_v, rel_v;
    logic [VOL_W:0]      dec_floor;

    always_comb begin
        cur_st    = env_q[idx_q];
        cur_vol   = vol_q[idx_q];
        cur_hold  = hold_q[idx_q];
        cur_press = press_q[idx_q];
        cur_rel   = rel_q[idx_q];
        is_drum   = (chan_q[idx_q] == DRUM_CH);

        sus_full  = {1'b0, i_sustain_value, {(VOL_W-1-RATE_W){1'b0}}};
        dec_v     = {{(VOL_W-RATE_W){1'b0}}, i_decay_rate};
        rel_v     = {{(VOL_W-RATE_W){1'b0}}, i_release_rate};
        atk_sum   = {1'b0, cur_vol} + {{(VOL_W+1-RATE_W){1'b0}}, i_attack_rate};
        // vol - dec <= sus rewritten as vol <= sus + dec so nothing can wrap
        dec_floor = {1'b0, sus_full} + {1'b0, dec_v};

        nxt_st    = cur_st;
        nxt_vol   = cur_vol;
        nxt_hold  = cur_hold;
        clr_press = 1'b0;
        clr_rel   = 1'b0;

        if (is_drum) begin
            clr_rel = 1'b1;
            if (cur_press) begin
                clr_press = 1'b1;
                nxt_st    = ENV_ATTACK;
                nxt_vol   = VOL_MAX;
                nxt_hold  = HOLD_INIT;
            end else begin
                case (cur_st)
                    ENV_BLANK: begin
                        nxt_st  = ENV_BLANK;
                    end
                    ENV_ATTACK, ENV_SUSTAIN: begin
                        if (cur_hold == '0) begin
                            nxt_st  = ENV_BLANK;
                            nxt_vol = '0;
                        end else begin
                            nxt_st   = ENV_SUSTAIN;
                            nxt_vol  = VOL_MAX;
                            nxt_hold = cur_hold - HOLD_W'(1);
                        end
                    end
                    default: begin
                        nxt_st  = ENV_BLANK;
                        nxt_vol = '0;
                    end
                endcase
            end
        end else begin
            case (cur_st)
                ENV_BLANK: begin
                    // a release waiting on a silent voice has nothing to do
                    clr_rel = 1'b1;
                    if (cur_press) begin
                        clr_press = 1'b1;
                        nxt_st    = ENV_ATTACK;
                    end
                end
                ENV_ATTACK: begin
                    if (cur_rel) begin
                        clr_rel = 1'b1;
                        nxt_st  = ENV_RELEASE;
                    end else if (atk_sum >= {1'b0, VOL_MAX}) begin
                        nxt_st  = ENV_DECAY;
                        nxt_vol = VOL_MAX;
                    end else begin
                        nxt_vol = atk_sum[VOL_W-1:0];
                    end
                end
                ENV_DECAY: begin
                    if (cur_rel) begin
                        clr_rel = 1'b1;
                        nxt_st  = ENV_RELEASE;
                    end else if (cur_press) begin
                        clr_press = 1'b1;
                        nxt_st    = ENV_ATTACK;
                    end else if ({1'b0, cur_vol} <= dec_floor) begin
                        nxt_st  = ENV_SUSTAIN;
                        nxt_vol = sus_full;
                    end else begin
                        nxt_vol = cur_vol - dec_v;
                    end
                end
                ENV_SUSTAIN: begin
                    if (cur_press) begin
                        clr_press = 1'b1;
                        nxt_st    = ENV_ATTACK;
                    end else if (cur_rel) begin
                        clr_rel = 1'b1;
                        nxt_st  = ENV_RELEASE;
                    end else begin
                        nxt_vol = sus_full;
                    end
                end
                ENV_RELEASE: begin
                    if (cur_press) begin
                        clr_press = 1'b1;
                        nxt_st    = ENV_ATTACK;
                    end else if (cur_vol < rel_v) begin
                        nxt_st  = ENV_BLANK;
                        nxt_vol = '0;
                    end else begin
                        nxt_vol = cur_vol - rel_v;
                    end
                end
                default: begin
                    nxt_st  = ENV_BLANK;
                    nxt_vol = '0;
                end
            endcase
        end
    end

    always_comb begin
        ctl_d     = ctl_q;
        idx_d     = idx_q;
        env_d     = env_q;
        vol_d     = vol_q;
        chan_d    = chan_q;
        hold_d    = hold_q;
        press_d   = press_q;
        rel_d     = rel_q;
        valid_d   = 1'b0;
        voice_d   = voice_q;
        st_out_d  = st_out_q;
        vol_out_d = vol_out_q;
        done_d    = 1'b0;
        ovr_d     = 1'b0;

        case (ctl_q)
            CTL_IDLE: begin
                if (i_sample_tick) begin
                    ctl_d = CTL_SWEEP;
                    idx_d = '0;
                end
            end
            CTL_SWEEP: begin
                ovr_d         = i_sample_tick;
                env_d[idx_q]  = nxt_st;
                vol_d[idx_q]  = nxt_vol;
                hold_d[idx_q] = nxt_hold;
                if (clr_press) press_d[idx_q] = 1'b0;
                if (clr_rel)   rel_d[idx_q]   = 1'b0;
                valid_d   = 1'b1;
                voice_d   = idx_q;
                st_out_d  = nxt_st;
                vol_out_d = nxt_vol;
                idx_d     = idx_q + VI_W'(1);
                if (idx_q == LAST_IDX) begin
                    ctl_d  = CTL_IDLE;
                    done_d = 1'b1;
                end
            end
            default: ctl_d = CTL_IDLE;
        endcase

        // Applied after the consume-clear so an event landing on the voice
        // being processed survives into the next sweep.
        if (i_evt_valid) begin
            press_d[i_evt_voice] = i_evt_on;
            rel_d[i_evt_voice]   = ~i_evt_on;
            if (i_evt_on) chan_d[i_evt_voice] = i_evt_channel;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctl_q     <= CTL_IDLE;
            idx_q     <= '0;
            press_q   <= '0;
            rel_q     <= '0;
            valid_q   <= 1'b0;
            voice_q   <= '0;
            st_out_q  <= '0;
            vol_out_q <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                env_q[i]  <= ENV_BLANK;
                vol_q[i]  <= '0;
                chan_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            ctl_q     <= ctl_d;
            idx_q     <= idx_d;
            env_q     <= env_d;
            vol_q     <= vol_d;
            chan_q    <= chan_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
            valid_q   <= valid_d;
            voice_q   <= voice_d;
            st_out_q  <= st_out_d;
            vol_out_q <= vol_out_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
        end
    end

    assign o_env_valid    = valid_q;
    assign o_env_voice    = voice_q;
    assign o_env_state    = st_out_q;
    assign o_env_volume   = vol_out_q;
    assign o_sweep_done   = done_q;
    assign o_busy         = (ctl_q == CTL_SWEEP);
    assign o_tick_overrun = ovr_q;

endmodule
